// File: rtl/frame_scheduler.sv
// Sender map path frame sequencer: primes on FIFO fill, pops payload bytes only in
// payload slots, and presents position plus payload cycle-aligned to the frame controller.
module frame_scheduler #(
   parameter int unsigned ROWS        = 4,
   parameter int unsigned COLS        = 1041,
   parameter int unsigned OH_COLS     = 16,
   parameter int unsigned PRIME_LEVEL = 64,
   parameter int unsigned LVL_W       = 12
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_fifo_empty,
   input  logic [LVL_W-1:0] i_fifo_level,
   input  logic [7:0]       i_fifo_data,
   output logic             o_fifo_rd,
   input  logic             i_clr_underrun,
   output logic [1:0]       o_row_cnt,
   output logic [10:0]      o_col_cnt,
   output logic [7:0]       o_pyld_data,
   output logic             o_pyld_data_valid,
   output logic             o_pos_valid,
   output logic             o_frame_start,
   output logic             o_busy,
   output logic             o_underrun,
   output logic [15:0]      o_underrun_cnt
);
   localparam int unsigned ROW_W = 2;
   localparam int unsigned COL_W = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t           state;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             run;
   logic             slot;
   logic             last_col;
   logic             last_slot;
   logic             underrun_ev;

   // Slot decode from the internal position; col COLS-1 is stuffing, never payload.
   assign run         = (state == RUN);
   assign slot        = (col >= COL_W'(OH_COLS)) && (col <= COL_W'(COLS - 2));
   assign last_col    = (col == COL_W'(COLS - 1));
   assign last_slot   = last_col && (row == ROW_W'(ROWS - 1));
   assign underrun_ev = run && slot && i_fifo_empty;
   assign o_fifo_rd   = run && slot && !i_fifo_empty;
   assign o_busy      = (state != IDLE);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state             <= IDLE;
         row               <= '0;
         col               <= '0;
         o_row_cnt         <= '0;
         o_col_cnt         <= '0;
         o_pyld_data       <= '0;
         o_pyld_data_valid <= 1'b0;
         o_pos_valid       <= 1'b0;
         o_frame_start     <= 1'b0;
         o_underrun        <= 1'b0;
         o_underrun_cnt    <= '0;
      end else begin
         o_row_cnt         <= '0;
         o_col_cnt         <= '0;
         o_pyld_data       <= '0;
         o_pyld_data_valid <= 1'b0;
         o_pos_valid       <= 1'b0;
         o_frame_start     <= 1'b0;

         unique case (state)
            IDLE: begin
               row <= '0;
               col <= '0;
               if (i_en) state <= PRIME;
            end
            PRIME: begin
               if (!i_en) state <= IDLE;
               else if (i_fifo_level >= LVL_W'(PRIME_LEVEL)) state <= RUN;
            end
            RUN: begin
               o_row_cnt         <= row;
               o_col_cnt         <= col;
               o_pos_valid       <= 1'b1;
               o_frame_start     <= (row == '0) && (col == '0);
               o_pyld_data_valid <= o_fifo_rd;
               o_pyld_data       <= o_fifo_rd ? i_fifo_data : 8'h00;
               // Enable is only honoured at the frame boundary so frames are never cut short.
               if (last_slot) begin
                  row <= '0;
                  col <= '0;
                  if (!i_en) state <= IDLE;
               end else if (last_col) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Clear takes priority and drops a coincident underrun event.
         if (i_clr_underrun) begin
            o_underrun     <= 1'b0;
            o_underrun_cnt <= '0;
         end else if (underrun_ev) begin
            o_underrun <= 1'b1;
            if (o_underrun_cnt != '1) o_underrun_cnt <= o_underrun_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed/randomized bench for frame_scheduler against a frame-index reference model.
`timescale 1ns/1ps
module tb_frame_scheduler;
   localparam int ROWS        = 4;
   localparam int COLS        = 1041;
   localparam int OH_COLS     = 16;
   localparam int PRIME_LEVEL = 64;
   localparam int FRAME       = ROWS * COLS;
   localparam int S_IDLE      = 0;
   localparam int S_PRIME     = 1;
   localparam int S_RUN       = 2;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        en         = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [11:0] level      = '0;
   logic [7:0]  fdata      = '0;
   logic        clr        = 1'b0;
   logic        fifo_rd;
   logic [1:0]  row_cnt;
   logic [10:0] col_cnt;
   logic [7:0]  pyld_data;
   logic        pyld_valid;
   logic        pos_valid;
   logic        frame_start;
   logic        busy;
   logic        underrun;
   logic [15:0] underrun_cnt;

   always #5 clk = ~clk;

   frame_scheduler dut (
      .i_clk             (clk),
      .i_rst             (rst_n),
      .i_en              (en),
      .i_fifo_empty      (fifo_empty),
      .i_fifo_level      (level),
      .i_fifo_data       (fdata),
      .o_fifo_rd         (fifo_rd),
      .i_clr_underrun    (clr),
      .o_row_cnt         (row_cnt),
      .o_col_cnt         (col_cnt),
      .o_pyld_data       (pyld_data),
      .o_pyld_data_valid (pyld_valid),
      .o_pos_valid       (pos_valid),
      .o_frame_start     (frame_start),
      .o_busy            (busy),
      .o_underrun        (underrun),
      .o_underrun_cnt    (underrun_cnt)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: mode plus linear slot index within the frame.
   int m_st   = S_IDLE;
   int m_k    = 0;
   int m_cnt  = 0;
   int m_flag = 0;
   int e_row, e_col, e_pv, e_fs, e_dv, e_data;

   int cyc       = 0;
   int last_fs   = -1;
   int fs_seen   = 0;
   int dut_pops  = 0;
   int ramp      = 0;
   int ramp_head = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_row"},   32'(row_cnt), 0);
      chk({tag, "_col"},   32'(col_cnt), 0);
      chk({tag, "_data"},  32'(pyld_data), 0);
      chk({tag, "_dv"},    32'(pyld_valid), 0);
      chk({tag, "_pv"},    32'(pos_valid), 0);
      chk({tag, "_fs"},    32'(frame_start), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_uflag"}, 32'(underrun), 0);
      chk({tag, "_ucnt"},  32'(underrun_cnt), 0);
      chk({tag, "_rd"},    32'(fifo_rd), 0);
   endtask

   // One clock: check the pop strobe mid-cycle, advance the model, check registered outputs.
   task automatic step();
      int r, c, slot, rd;
      if (ramp != 0) fdata = 8'(ramp_head);
      #2;
      r    = m_k / COLS;
      c    = m_k % COLS;
      slot = (m_st == S_RUN && c >= OH_COLS && c <= COLS - 2) ? 1 : 0;
      rd   = (slot != 0 && !fifo_empty) ? 1 : 0;
      chk("fifo_rd", 32'(fifo_rd), rd);
      if (fifo_rd === 1'b1) dut_pops++;
      if (ramp != 0 && rd != 0) ramp_head++;
      if (m_st == S_RUN) begin
         e_row = r; e_col = c; e_pv = 1; e_fs = (m_k == 0) ? 1 : 0;
         e_dv = rd; e_data = (rd != 0) ? int'(fdata) : 0;
      end else begin
         e_row = 0; e_col = 0; e_pv = 0; e_fs = 0; e_dv = 0; e_data = 0;
      end
      if (clr) begin
         m_cnt = 0; m_flag = 0;
      end else if (slot != 0 && fifo_empty) begin
         m_flag = 1;
         if (m_cnt < 65535) m_cnt++;
      end
      case (m_st)
         S_IDLE:  if (en) m_st = S_PRIME;
         S_PRIME: if (!en) m_st = S_IDLE;
                  else if (int'(level) >= PRIME_LEVEL) begin m_st = S_RUN; m_k = 0; end
         default: if (m_k == FRAME - 1) begin m_k = 0; if (!en) m_st = S_IDLE; end
                  else m_k++;
      endcase
      @(posedge clk);
      #1;
      cyc++;
      chk("row",   32'(row_cnt), e_row);
      chk("col",   32'(col_cnt), e_col);
      chk("pos_v", 32'(pos_valid), e_pv);
      chk("fs",    32'(frame_start), e_fs);
      chk("dv",    32'(pyld_valid), e_dv);
      chk("data",  32'(pyld_data), e_data);
      chk("busy",  32'(busy), (m_st != S_IDLE) ? 1 : 0);
      chk("uflag", 32'(underrun), m_flag);
      chk("ucnt",  32'(underrun_cnt), m_cnt);
      if (frame_start === 1'b1) begin
         if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), FRAME);
         last_fs = cyc;
         fs_seen++;
      end
      if (m_st != S_RUN) last_fs = -1;
   endtask

   task automatic rand_inputs(input int empty_one_in);
      fdata      = 8'($urandom);
      level      = 12'($urandom);
      fifo_empty = (empty_one_in > 0) ? ($urandom_range(0, empty_one_in - 1) == 0) : 1'b0;
   endtask

   initial begin
      int fs_mark;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // Level one short of the threshold keeps the block priming
      en = 1'b1; level = 12'd63; fifo_empty = 1'b0;
      repeat (100) begin fdata = 8'($urandom); step(); end
      chk("prime_busy", 32'(busy), 1);
      chk("prime_pv", 32'(pos_valid), 0);

      // Threshold reached; first frame with a ramp pattern from a never-empty FIFO
      level = 12'd64; ramp = 1;
      step();
      dut_pops = 0;
      repeat (17) step();
      chk("first_byte_col", 32'(col_cnt), OH_COLS);
      chk("first_byte_val", 32'(pyld_data), 0);
      chk("first_byte_dv",  32'(pyld_valid), 1);
      repeat (FRAME - 17) step();
      chk("pops_per_frame", 32'(dut_pops), 4096);
      ramp = 0;

      // Second frame: three consecutive empty slots from row 1 col 500
      for (int i = 0; i < FRAME; i++) begin
         fdata = 8'($urandom);
         level = 12'($urandom);
         fifo_empty = (m_k >= COLS + 500 && m_k <= COLS + 502);
         step();
      end
      chk("urun_cnt3",  32'(underrun_cnt), 3);
      chk("urun_flag",  32'(underrun), 1);

      // Third frame: random empties/clears, enable dropped at row 1 col 200
      fs_mark = -1;
      for (int i = 0; i < 2 * FRAME && m_st != S_IDLE; i++) begin
         rand_inputs(8);
         clr = ($urandom_range(0, 255) == 0);
         if (m_k == COLS + 200 && fs_mark < 0) fs_mark = fs_seen;
         if (fs_mark >= 0) en = 1'b0;
         step();
      end
      clr = 1'b0;
      chk("stop_busy", 32'(busy), 0);
      repeat (50) begin rand_inputs(2); step(); end
      chk("no_restart_fs", 32'(fs_seen - fs_mark), 0);

      // Saturation and clear priority
      en = 1'b1; level = 12'd100; fifo_empty = 1'b0;
      repeat (22) begin fdata = 8'($urandom); step(); end
      force dut.o_underrun_cnt = 16'hFFFE;
      #1;
      release dut.o_underrun_cnt;
      m_cnt = 65534;
      step();
      fifo_empty = 1'b1;
      step();
      chk("sat_reach", 32'(underrun_cnt), 32'hFFFF);
      step();
      chk("sat_hold", 32'(underrun_cnt), 32'hFFFF);
      clr = 1'b1;
      step();
      chk("clr_wins_cnt",  32'(underrun_cnt), 0);
      chk("clr_wins_flag", 32'(underrun), 0);
      clr = 1'b0; fifo_empty = 1'b0;

      // Asynchronous reset at row 2 col 700
      for (int i = 0; i < 2 * FRAME && !(m_st == S_RUN && m_k == 2 * COLS + 700); i++) begin
         rand_inputs(16);
         step();
      end
      rand_inputs(0);
      step();
      chk("pre_rst_row", 32'(row_cnt), 2);
      chk("pre_rst_col", 32'(col_cnt), 700);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      m_st = S_IDLE; m_k = 0; m_cnt = 0; m_flag = 0; last_fs = -1;
      @(posedge clk);
      #1;
      rst_n = 1'b1; en = 1'b1; level = 12'd200; fifo_empty = 1'b0;
      fs_mark = fs_seen;
      repeat (30) begin fdata = 8'($urandom); step(); end
      chk("restart_fs", 32'(fs_seen - fs_mark), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
